// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH+1 cycles from accept to done.
// Optional signed mode is enabled by defining SEQ_MULT_SIGNED_EN (adds the sgn input).
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               sgn,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic                 accept_sgn;
    logic [AW-1:0]        a_ext;
    logic [AW-1:0]        partial;
    logic [AW-1:0]        acc_sum;

`ifdef SEQ_MULT_SIGNED_EN
    logic sgn_q, sgn_d;
    assign signed_op  = sgn_q;
    assign accept_sgn = sgn;
`else
    assign signed_op  = 1'b0;
    assign accept_sgn = 1'b0;
`endif

    // In signed mode the multiplier's MSB carries weight -2^(WIDTH-1), hence the final subtract.
    always_comb begin
        a_ext   = {{(AW - WIDTH){signed_op & a_q[WIDTH-1]}}, a_q};
        partial = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
        if (signed_op && (cnt_q == LAST)) begin
            acc_sum = acc_q - partial;
        end else begin
            acc_sum = acc_q + partial;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        p_d     = p_q;
        ready_d = ready_q;
        done_d  = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        sgn_d   = sgn_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    ready_d = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
                    sgn_d   = accept_sgn;
`endif
                end else begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    p_d     = acc_sum[2*WIDTH-1:0];
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign p     = p_q;

    logic unused_sgn;
    assign unused_sgn = accept_sgn;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=4 and WIDTH=8: directed cases plus random traffic
// checked against plain integer multiplication.
module tb_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fin   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     t;
        longint p;
    } exp_t;

`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_w
        localparam int W    = (gi == 0) ? 4 : 8;
        localparam int NOPS = (gi == 0) ? 1500 : 2000;
        localparam longint MASK = (longint'(1) << W) - 1;

        logic               rst   = 1'b1;
        logic               start = 1'b0;
        logic [W-1:0]       a     = '0;
        logic [W-1:0]       b     = '0;
        logic               ready;
        logic               done;
        logic [2*W-1:0]     p;
`ifdef SEQ_MULT_SIGNED_EN
        logic               sgn   = 1'b0;
`endif

        seq_mult #(.WIDTH(W)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
`ifdef SEQ_MULT_SIGNED_EN
            .sgn   (sgn),
`endif
            .a     (a),
            .b     (b),
            .ready (ready),
            .done  (done),
            .p     (p)
        );

        exp_t   q[$];
        longint exp_p = 0;

        function automatic longint model(longint x, longint y, bit s);
            longint lim = longint'(1) << W;
            longint sx = x;
            longint sy = y;
            if (s && sx >= lim / 2) sx = sx - lim;
            if (s && sy >= lim / 2) sy = sy - lim;
            return (sx * sy) & ((longint'(1) << (2 * W)) - 1);
        endfunction

        task automatic check(string name, longint act, longint req);
            total = total + 1;
            if (act != req) begin
                bad = bad + 1;
                $display("FAIL W=%0d %s at cycle %0d: got %0h expected %0h", W, name, cyc, act, req);
            end
        endtask

        task automatic step(bit st, longint x, longint y, bit s, output bit acc);
            longint xm = x & MASK;
            longint ym = y & MASK;
            bit     se = s & SIGNED_BUILD;
            exp_t   e;
            @(negedge clk);
            start = st;
            a = W'(xm);
            b = W'(ym);
`ifdef SEQ_MULT_SIGNED_EN
            sgn = s;
`endif
            acc = st && (ready === 1'b1) && !rst;
            if (acc) begin
                e.t = cyc;
                e.p = model(xm, ym, se);
                q.push_back(e);
                $display("W=%0d issue a=%0h b=%0h sgn=%0d expect p=%0h", W, xm, ym, se, e.p);
            end
        endtask

        task automatic idle(int n);
            bit acc;
            repeat (n) step(1'b0, longint'($urandom), longint'($urandom), 1'b0, acc);
        endtask

        // Holds start with fixed operands until accepted, then scrambles the operand inputs.
        task automatic issue(longint x, longint y, bit s);
            bit acc = 1'b0;
            int n = 0;
            while (!acc && n < 60) begin
                step(1'b1, x, y, s, acc);
                n++;
            end
            if (!acc) check("accept_timeout", 0, 1);
            step(1'b0, longint'($urandom), longint'($urandom), 1'b0, acc);
        endtask

        task automatic do_reset();
            @(negedge clk);
            rst = 1'b1;
            start = 1'b0;
            q.delete();
            @(negedge clk);
            rst = 1'b0;
        endtask

        always begin : mon
            bit     r;
            bit     due;
            bit     busy;
            int     age;
            exp_t   e;
            @(posedge clk);
            r = rst;
            #1;
            if (r) begin
                check("rst_ready", longint'(ready), 1);
                check("rst_done", longint'(done), 0);
                check("rst_p", longint'(p), 0);
                exp_p = 0;
            end else begin
                due  = 1'b0;
                busy = 1'b0;
                if (q.size() != 0) begin
                    age  = cyc - q[0].t;
                    due  = (age == W + 1);
                    busy = (age <= W);
                end
                check("ready", longint'(ready), longint'(!busy));
                check("done", longint'(done), longint'(due));
                if (due) begin
                    e = q.pop_front();
                    exp_p = e.p;
                    $display("W=%0d done p=%0h expect %0h", W, p, exp_p);
                end
                check("p", longint'(p), exp_p);
            end
        end

        initial begin : stim
            int r;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            idle(2);

            issue(15, 15, 1'b0);
            idle(W + 3);
            issue(0, 9, 1'b0);
            issue(13, 11, 1'b0);
            idle(W + 3);
            begin : ignored_start
                bit acc;
                issue(5, 3, 1'b0);
                step(1'b1, 1, 1, 1'b0, acc);
                step(1'b0, 0, 0, 1'b0, acc);
            end
            idle(W + 3);
            issue(7, 9, 1'b0);
            idle(1);
            do_reset();
            idle(2);
            issue(MASK, MASK, 1'b0);
            issue(0, 0, 1'b0);
            issue(1, MASK, 1'b0);
            idle(W + 3);
`ifdef SEQ_MULT_SIGNED_EN
            issue(-8, -8, 1'b1);
            issue(-8, 7, 1'b1);
            issue(-1, 1, 1'b1);
            issue(8, 8, 1'b0);
            issue(MASK, MASK, 1'b1);
            idle(W + 3);
`endif
            for (int i = 0; i < NOPS; i++) begin
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    do_reset();
                end else if (r < 60) begin
                    issue(longint'($urandom), longint'($urandom), 1'($urandom));
                end else begin
                    bit acc;
                    step(1'($urandom), longint'($urandom), longint'($urandom), 1'($urandom), acc);
                end
            end
            idle(W + 3);
            check("drain", longint'(q.size()), 0);
            fin = fin + 1;
        end
    end

    initial begin
        fork
            wait (fin == 2);
            #3000000;
        join_any
        if (fin != 2) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL timeout: finished=%0d expected 2", fin);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
